// File: rtl/prio_enc_pkg.sv
// Shared definitions for the sequential priority scan encoder.
package prio_enc_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  // True when exactly one bit of a (zero-extended) vector is set.
  function automatic logic popcnt_is_one(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage : prio_enc_pkg

// File: rtl/prio_find_first.sv
// Combinational find-first-set starting at an arbitrary offset, searching
// upward (DOWN=0) or downward (DOWN=1) with wrap-around.
module prio_find_first #(
  parameter int unsigned  N    = 8,
  parameter bit           DOWN = 1'b0,
  localparam int unsigned IW   = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;

  // Map a search slot (0 = searched first) back to a bit position.
  function automatic logic [IW-1:0] slot(input logic [IW-1:0] s,
                                         input logic [IW-1:0] j);
    int unsigned p;
    if (DOWN) p = 32'(s) + N - 32'(j);
    else      p = 32'(s) + 32'(j);
    if (p >= N) p = p - N;
    return IW'(p);
  endfunction

  // Rotate the vector so the search always runs from slot 0 upward.
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = vec[slot(start, IW'(j))];
    end
  end

  // Plain priority scan: lowest set slot wins.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = IW'(j);
      end
    end
  end

  // Un-rotate the winning slot into a bit index.
  assign idx = slot(start, off);

endmodule : prio_find_first

// File: rtl/prio_scan_enc.sv
// Sequential priority encoder: accepts a multi-hot vector and reports one
// set-bit index per output handshake, fixed-priority or round-robin order.
module prio_scan_enc
  import prio_enc_pkg::*;
#(
  parameter int unsigned  N    = 8,
  parameter int unsigned  MODE = MODE_FIXED,
  localparam int unsigned IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          req_valid,
  output logic          req_ready,
  output logic [IW-1:0] idx,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic          last,
  output logic          none
);

  state_e        state_q, state_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          zero_q, zero_d;

  logic [IW-1:0] ff_idx;
  logic          ff_found;
  logic [IW-1:0] ff_start;
  logic          beat;
  logic          load;

  // Fixed mode always scans down from the top bit; round-robin from ptr.
  assign ff_start = (MODE == MODE_RR) ? ptr_q : IW'(N - 1);

  prio_find_first #(
    .N    (N),
    .DOWN (MODE == MODE_FIXED)
  ) u_find (
    .vec   (pend_q),
    .start (ff_start),
    .idx   (ff_idx),
    .found (ff_found)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state and output decode; outputs depend only on registers except
  // req_ready, which allows reload on the final accepted beat.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ptr_d     = ptr_q;
    zero_d    = zero_q;
    req_ready = 1'b0;
    idx_valid = 1'b0;
    idx       = '0;
    last      = 1'b0;
    none      = 1'b0;
    beat      = 1'b0;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        load      = req_valid;
        if (load) begin
          pend_d  = req;
          zero_d  = (req == '0);
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        idx_valid = 1'b1;
        idx       = ff_found ? ff_idx : '0;
        none      = zero_q;
        last      = zero_q | popcnt_is_one(64'(pend_q));
        beat      = idx_ready;
        req_ready = beat & last;
        load      = req_valid & req_ready;

        if (beat) begin
          pend_d = pend_q & ~(N'(1) << idx);
          // The zero-vector beat does not move the round-robin pointer.
          if ((MODE == MODE_RR) && !zero_q) begin
            ptr_d = (32'(idx) == N - 1) ? '0 : IW'(32'(idx) + 1);
          end
          if (last) begin
            state_d = S_IDLE;
            zero_d  = 1'b0;
          end
        end

        // Same-cycle reload keeps the scan running with no bubble.
        if (load) begin
          pend_d  = req;
          zero_d  = (req == '0);
          state_d = S_SCAN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule : prio_scan_enc
